// File: rtl/mod99_dncnt_ctrl.sv
// Sequencer for the mod-99 down counter: owns the count register, feeds the
// external ripple subtractor (count - 1) and commits its difference on each prescaled tick.
module mod99_dncnt_ctrl #(
    parameter int MODULUS  = 99,
    parameter int WIDTH    = 7,
    parameter int TICK_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] sub_a,
    output logic [WIDTH-1:0] sub_b,
    input  logic [WIDTH-1:0] sub_diff,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
    localparam logic [7:0]       PS_MAX  = 8'(TICK_DIV - 1);

    state_t           state, state_nxt;
    logic [7:0]       prescaler, prescaler_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] load_clamped;
    logic             tc_nxt;
    logic             tick;

    assign sub_a        = count;
    assign sub_b        = WIDTH'(1);
    assign load_clamped = (load_val > CNT_MAX) ? CNT_MAX : load_val;
    assign tick         = (state == RUN) && (prescaler == PS_MAX);
    assign busy         = (state == RUN);
    assign done         = (state == DONE);

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        prescaler_nxt = prescaler;
        tc_nxt        = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    count_nxt     = load_clamped;
                    prescaler_nxt = '0;
                end
                if (start) state_nxt = RUN;
            end
            HOLD: begin
                if (load) begin
                    count_nxt     = load_clamped;
                    prescaler_nxt = '0;
                end
                if (start && !stop) state_nxt = RUN;
            end
            DONE: begin
                if (load) begin
                    count_nxt     = load_clamped;
                    prescaler_nxt = '0;
                    state_nxt     = HOLD;
                end
                if (start) state_nxt = RUN;
            end
            RUN: begin
                // A cycle in which stop is sampled still counts as a RUN cycle.
                prescaler_nxt = tick ? '0 : prescaler + 8'd1;
                if (stop) state_nxt = HOLD;
                if (tick) begin
                    if (count != '0) begin
                        count_nxt = sub_diff;
                    end else if (auto_reload) begin
                        count_nxt = CNT_MAX;
                        tc_nxt    = 1'b1;
                    end else begin
                        tc_nxt    = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            prescaler <= '0;
            tc        <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            prescaler <= prescaler_nxt;
            tc        <= tc_nxt;
        end
    end

endmodule

// File: tb/tb_mod99_dncnt_ctrl.sv
// Directed bench for mod99_dncnt_ctrl: one instance with TICK_DIV=1, one with TICK_DIV=4,
// each paired with a behavioural subtractor on its sub_a/sub_b/sub_diff loop.
module tb_mod99_dncnt_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [6:0] load_val = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       auto_reload = 1'b0;

    logic [6:0] sub_a1, sub_b1, diff1, count1;
    logic       busy1, done1, tc1;
    logic [6:0] sub_a4, sub_b4, diff4, count4;
    logic       busy4, done4, tc4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign diff1 = sub_a1 - sub_b1;
    assign diff4 = sub_a4 - sub_b4;

    mod99_dncnt_ctrl #(.MODULUS(99), .WIDTH(7), .TICK_DIV(1)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .auto_reload(auto_reload),
        .sub_a(sub_a1), .sub_b(sub_b1), .sub_diff(diff1),
        .count(count1), .busy(busy1), .done(done1), .tc(tc1)
    );

    mod99_dncnt_ctrl #(.MODULUS(99), .WIDTH(7), .TICK_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .auto_reload(auto_reload),
        .sub_a(sub_a4), .sub_b(sub_b4), .sub_diff(diff4),
        .count(count4), .busy(busy4), .done(done4), .tc(tc4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        load = 1'b0; start = 1'b0; stop = 1'b0; auto_reload = 1'b0; load_val = '0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        load = 1'b1; load_val = 7'd45; start = 1'b1;
        step();
        load = 1'b0; start = 1'b0;
        repeat (5) step();
        n_checks++; if (count1 !== 7'd40) $display("FAIL reset_pre_count: got %0d want 40", count1); else n_pass++;
        n_checks++; if (busy1 !== 1'b1) $display("FAIL reset_pre_busy: got %b want 1", busy1); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (count1 !== 7'd0) $display("FAIL reset_async_count: got %0d want 0", count1); else n_pass++;
        n_checks++; if ({busy1, done1, tc1} !== 3'b000) $display("FAIL reset_async_flags: got %b want 000", {busy1, done1, tc1}); else n_pass++;
        step();
        rst_n = 1'b1;
        step();
        n_checks++; if ({busy1, done1, tc1} !== 3'b000) $display("FAIL reset_idle_flags: got %b want 000", {busy1, done1, tc1}); else n_pass++;
        n_checks++; if (count1 !== 7'd0) $display("FAIL reset_idle_count: got %0d want 0", count1); else n_pass++;
        n_checks++; if (sub_b1 !== 7'd1) $display("FAIL sub_b_const: got %0d want 1", sub_b1); else n_pass++;
    endtask

    task automatic test_clamp();
        do_reset();
        load = 1'b1; load_val = 7'd120;
        step();
        n_checks++; if (count1 !== 7'd98) $display("FAIL clamp_120: got %0d want 98", count1); else n_pass++;
        n_checks++; if (busy1 !== 1'b0) $display("FAIL clamp_busy: got %b want 0", busy1); else n_pass++;
        load_val = 7'd98;
        step();
        n_checks++; if (count1 !== 7'd98) $display("FAIL clamp_98: got %0d want 98", count1); else n_pass++;
        load_val = 7'd0;
        step();
        n_checks++; if (count1 !== 7'd0) $display("FAIL clamp_0: got %0d want 0", count1); else n_pass++;
        n_checks++; if (sub_a1 !== 7'd0) $display("FAIL clamp_sub_a: got %0d want 0", sub_a1); else n_pass++;
        load = 1'b0;
    endtask

    task automatic test_oneshot();
        do_reset();
        load = 1'b1; load_val = 7'd5; start = 1'b1;
        step();
        load = 1'b0; start = 1'b0;
        n_checks++; if (count1 !== 7'd5 || busy1 !== 1'b1) $display("FAIL oneshot_start: got count %0d busy %b want 5 1", count1, busy1); else n_pass++;
        for (int k = 4; k >= 0; k--) begin
            step();
            n_checks++; if (count1 !== 7'(k) || tc1 !== 1'b0) $display("FAIL oneshot_count: got %0d tc %b want %0d tc 0", count1, tc1, k); else n_pass++;
        end
        step();
        n_checks++; if ({tc1, done1, busy1} !== 3'b110 || count1 !== 7'd0) $display("FAIL oneshot_term: got tc/done/busy %b count %0d want 110 0", {tc1, done1, busy1}, count1); else n_pass++;
        step();
        n_checks++; if ({tc1, done1} !== 2'b01 || count1 !== 7'd0) $display("FAIL oneshot_after: got tc/done %b count %0d want 01 0", {tc1, done1}, count1); else n_pass++;
    endtask

    task automatic test_done_restart();
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if ({busy1, tc1} !== 2'b10 || count1 !== 7'd0) $display("FAIL restart_run: got busy/tc %b count %0d want 10 0", {busy1, tc1}, count1); else n_pass++;
        step();
        n_checks++; if ({tc1, done1} !== 2'b11) $display("FAIL restart_tc: got tc/done %b want 11", {tc1, done1}); else n_pass++;
        step();
        n_checks++; if (tc1 !== 1'b0) $display("FAIL restart_tc_clear: got %b want 0", tc1); else n_pass++;
        load = 1'b1; load_val = 7'd3;
        step();
        load = 1'b0;
        n_checks++; if (count1 !== 7'd3 || {busy1, done1} !== 2'b00) $display("FAIL done_load_hold: got count %0d busy/done %b want 3 00", count1, {busy1, done1}); else n_pass++;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        n_checks++; if (count1 !== 7'd2 || busy1 !== 1'b1) $display("FAIL hold_resume: got count %0d busy %b want 2 1", count1, busy1); else n_pass++;
    endtask

    task automatic test_auto_reload();
        do_reset();
        auto_reload = 1'b1; load = 1'b1; load_val = 7'd1; start = 1'b1;
        step();
        load = 1'b0; start = 1'b0;
        n_checks++; if (count1 !== 7'd1 || tc1 !== 1'b0) $display("FAIL reload_1: got %0d tc %b want 1 tc 0", count1, tc1); else n_pass++;
        step();
        n_checks++; if (count1 !== 7'd0 || tc1 !== 1'b0) $display("FAIL reload_0: got %0d tc %b want 0 tc 0", count1, tc1); else n_pass++;
        step();
        n_checks++; if (count1 !== 7'd98 || tc1 !== 1'b1 || done1 !== 1'b0) $display("FAIL reload_wrap: got %0d tc %b done %b want 98 1 0", count1, tc1, done1); else n_pass++;
        step();
        n_checks++; if (count1 !== 7'd97 || tc1 !== 1'b0 || done1 !== 1'b0 || busy1 !== 1'b1) $display("FAIL reload_97: got %0d tc %b done %b busy %b want 97 0 0 1", count1, tc1, done1, busy1); else n_pass++;
        stop = 1'b1;
        step();
        stop = 1'b0; auto_reload = 1'b0;
    endtask

    task automatic test_pause_resume();
        do_reset();
        load = 1'b1; load_val = 7'd52; start = 1'b1;
        step();
        load = 1'b0; start = 1'b0;
        step();
        n_checks++; if (count1 !== 7'd51) $display("FAIL pause_pre: got %0d want 51", count1); else n_pass++;
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_checks++; if (count1 !== 7'd50 || busy1 !== 1'b0) $display("FAIL pause_enter: got %0d busy %b want 50 0", count1, busy1); else n_pass++;
        for (int k = 0; k < 10; k++) begin
            step();
            n_checks++; if (count1 !== 7'd50 || busy1 !== 1'b0) $display("FAIL pause_hold_%0d: got %0d busy %b want 50 0", k, count1, busy1); else n_pass++;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if (count1 !== 7'd50 || busy1 !== 1'b1) $display("FAIL resume_run: got %0d busy %b want 50 1", count1, busy1); else n_pass++;
        step();
        n_checks++; if (count1 !== 7'd49) $display("FAIL resume_tick: got %0d want 49", count1); else n_pass++;
        load = 1'b1; load_val = 7'd10;
        step();
        load = 1'b0;
        n_checks++; if (count1 !== 7'd48) $display("FAIL run_load_ignored: got %0d want 48", count1); else n_pass++;
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_checks++; if (count1 !== 7'd47 || busy1 !== 1'b0) $display("FAIL pause_again: got %0d busy %b want 47 0", count1, busy1); else n_pass++;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        step();
        n_checks++; if (count1 !== 7'd47 || busy1 !== 1'b0) $display("FAIL start_stop_hold: got %0d busy %b want 47 0", count1, busy1); else n_pass++;
    endtask

    task automatic test_prescale();
        do_reset();
        load = 1'b1; load_val = 7'd3; start = 1'b1;
        step();
        load = 1'b0; start = 1'b0;
        n_checks++; if (count4 !== 7'd3 || busy4 !== 1'b1) $display("FAIL div4_start: got %0d busy %b want 3 1", count4, busy4); else n_pass++;
        for (int v = 2; v >= 1; v--) begin
            repeat (3) begin
                step();
                n_checks++; if (count4 !== 7'(v + 1)) $display("FAIL div4_wait: got %0d want %0d", count4, v + 1); else n_pass++;
            end
            step();
            n_checks++; if (count4 !== 7'(v)) $display("FAIL div4_tick: got %0d want %0d", count4, v); else n_pass++;
        end
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_checks++; if (count4 !== 7'd1 || busy4 !== 1'b0) $display("FAIL div4_pause: got %0d busy %b want 1 0", count4, busy4); else n_pass++;
        repeat (3) step();
        n_checks++; if (count4 !== 7'd1 || busy4 !== 1'b0) $display("FAIL div4_hold: got %0d busy %b want 1 0", count4, busy4); else n_pass++;
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if (count4 !== 7'd1 || busy4 !== 1'b1) $display("FAIL div4_resume: got %0d busy %b want 1 1", count4, busy4); else n_pass++;
        step();
        n_checks++; if (count4 !== 7'd1) $display("FAIL div4_resume_wait: got %0d want 1", count4); else n_pass++;
        step();
        n_checks++; if (count4 !== 7'd0 || tc4 !== 1'b0) $display("FAIL div4_resume_tick: got %0d tc %b want 0 0", count4, tc4); else n_pass++;
        repeat (3) step();
        n_checks++; if ({tc4, done4} !== 2'b00) $display("FAIL div4_pre_term: got tc/done %b want 00", {tc4, done4}); else n_pass++;
        step();
        n_checks++; if ({tc4, done4} !== 2'b11 || count4 !== 7'd0) $display("FAIL div4_term: got tc/done %b count %0d want 11 0", {tc4, done4}, count4); else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clamp();
        test_oneshot();
        test_done_restart();
        test_auto_reload();
        test_pause_resume();
        test_prescale();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
